// File: rtl/keypad_event_queue.sv
// Debounces the active-low keypad vector and queues key-press codes behind a valid/ready FIFO.
// Optional macro KEYPAD_RELEASE_EVENT_EN also queues release events, flagged by key_release.
module keypad_event_queue #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk_kb,
  input  logic        reset_n,
  input  logic [15:0] keys,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_release,
  output logic [15:0] key_state,
  output logic        any_pressed,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int ENTRY_W = 5;
`else
  localparam int ENTRY_W = 4;
`endif
  localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [15:0]        r_keysQ;
  logic [15:0]        r_keyState;
  logic [7:0]         r_debCnt;
  logic [15:0]        r_pressPend;
  logic               r_overflow;
  logic [ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;

  logic               w_stateUpdate;
  logic [15:0]        w_newPress;
  logic [15:0]        w_pressClr;
  logic [3:0]         w_pressIdx;
  logic               w_overflowSet;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_pushEntry;
  logic [ENTRY_W-1:0] w_headEntry;

`ifdef KEYPAD_RELEASE_EVENT_EN
  logic [15:0]        r_releasePend;
  logic [15:0]        w_newRelease;
  logic [15:0]        w_releaseClr;
  logic [3:0]         w_releaseIdx;
`endif

  function automatic logic [3:0] lowestIdx(input logic [15:0] v);
    lowestIdx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowestIdx = 4'(i);
    end
  endfunction

  // Counter saturates at DEB_LAST so key_state keeps reloading while keys is stable.
  assign w_stateUpdate = (keys == r_keysQ) && (r_debCnt == DEB_LAST);

  always_ff @(posedge clk_kb or negedge reset_n) begin
    if (!reset_n) begin
      r_keysQ    <= 16'hFFFF;
      r_keyState <= 16'hFFFF;
      r_debCnt   <= 8'd0;
    end else begin
      r_keysQ <= keys;
      if (keys != r_keysQ) begin
        r_debCnt <= 8'd0;
      end else if (r_debCnt == DEB_LAST) begin
        r_keyState <= r_keysQ;
      end else begin
        r_debCnt <= r_debCnt + 8'd1;
      end
    end
  end

  assign w_newPress = w_stateUpdate ? (r_keyState & ~r_keysQ) : 16'h0000;
`ifdef KEYPAD_RELEASE_EVENT_EN
  assign w_newRelease  = w_stateUpdate ? (~r_keyState & r_keysQ) : 16'h0000;
  assign w_overflowSet = (|(r_pressPend & w_newPress)) || (|(r_releasePend & w_newRelease));
`else
  assign w_overflowSet = |(r_pressPend & w_newPress);
`endif

  // Full uses the registered count, so a pop in the same cycle cannot open a slot.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = key_valid && key_ready;

  always_comb begin
    w_pressIdx  = lowestIdx(r_pressPend);
    w_pressClr  = 16'h0000;
    w_push      = 1'b0;
    w_pushEntry = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    w_releaseIdx = lowestIdx(r_releasePend);
    w_releaseClr = 16'h0000;
`endif
    if (!w_full) begin
      if (r_pressPend != 16'h0000) begin
        w_push                 = 1'b1;
        w_pressClr[w_pressIdx] = 1'b1;
        w_pushEntry            = ENTRY_W'(w_pressIdx);
      end
`ifdef KEYPAD_RELEASE_EVENT_EN
      else if (r_releasePend != 16'h0000) begin
        w_push                     = 1'b1;
        w_releaseClr[w_releaseIdx] = 1'b1;
        w_pushEntry                = {1'b1, w_releaseIdx};
      end
`endif
    end
  end

  always_ff @(posedge clk_kb or negedge reset_n) begin
    if (!reset_n) begin
      r_pressPend <= 16'h0000;
      r_overflow  <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      r_releasePend <= 16'h0000;
`endif
    end else begin
      r_pressPend <= (r_pressPend & ~w_pressClr) | w_newPress;
`ifdef KEYPAD_RELEASE_EVENT_EN
      r_releasePend <= (r_releasePend & ~w_releaseClr) | w_newRelease;
`endif
      if (w_overflowSet) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_kb or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the count is zero.
  always_ff @(posedge clk_kb) begin
    if (w_push) r_fifo[r_wrPtr] <= w_pushEntry;
  end

  assign w_headEntry = r_fifo[r_rdPtr];
  assign key_valid   = (r_count != '0);
  assign key_code    = key_valid ? w_headEntry[3:0] : 4'd0;
`ifdef KEYPAD_RELEASE_EVENT_EN
  assign key_release = key_valid && w_headEntry[4];
`else
  assign key_release = 1'b0;
`endif
  assign key_state   = r_keyState;
  assign any_pressed = (r_keyState != 16'hFFFF);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Self-checking bench for keypad_event_queue: vector table plus scoreboard of expected events.
// Works with or without KEYPAD_RELEASE_EVENT_EN; the event model follows the same macro.
`timescale 1ns/1ps
module tb_keypad_event_queue;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic        clk_kb = 1'b0;
  logic        reset_n;
  logic [15:0] keys;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_release;
  logic [15:0] key_state;
  logic        any_pressed;
  logic        overflow;

  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  sbQ[$];
  logic [15:0] modelState;
  logic [4:0]  monExp;
  int          firstIdx;
  int          validCnt;

  typedef struct {
    logic [15:0] keys;
    int          hold;
    logic [15:0] expState;
    logic        expAny;
  } vec_t;

  vec_t vecs[9];

  always #5 clk_kb = ~clk_kb;

  keypad_event_queue #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_kb     (clk_kb),
    .reset_n    (reset_n),
    .keys       (keys),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .key_state  (key_state),
    .any_pressed(any_pressed),
    .overflow   (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives a keys value for hold cycles; a value held long enough to debounce
  // queues its press (and, with the macro, release) events in encoder order.
  task automatic applyStimulus(input logic [15:0] v, input int hold, input bit queueEvents);
    logic [15:0] pressed;
`ifdef KEYPAD_RELEASE_EVENT_EN
    logic [15:0] released;
`endif
    keys = v;
    if (hold >= DEB + 1) begin
      pressed = modelState & ~v;
`ifdef KEYPAD_RELEASE_EVENT_EN
      released = ~modelState & v;
`endif
      if (queueEvents) begin
        for (int i = 0; i < 16; i++) if (pressed[i]) sbQ.push_back({1'b0, 4'(i)});
`ifdef KEYPAD_RELEASE_EVENT_EN
        for (int i = 0; i < 16; i++) if (released[i]) sbQ.push_back({1'b1, 4'(i)});
`endif
      end
      modelState = v;
    end
    repeat (hold) @(posedge clk_kb);
    @(negedge clk_kb);
  endtask

  // Every accepted head entry is matched against the scoreboard front.
  always @(negedge clk_kb) begin
    if (reset_n) begin
      if (key_valid && key_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got release=%0d code=%0d expected none",
                   key_release, key_code);
        end else begin
          monExp = sbQ.pop_front();
          checkOutput("event", {27'd0, key_release, key_code}, {27'd0, monExp});
        end
      end else if (!key_valid) begin
        checkOutput("idle_head", {27'd0, key_release, key_code}, 32'd0);
      end
    end
  end

  initial begin
    vecs[0] = '{16'hFFFE, 12, 16'hFFFE, 1'b1};
    vecs[1] = '{16'hFFFF, 12, 16'hFFFF, 1'b0};
    vecs[2] = '{16'hFFFE,  2, 16'hFFFF, 1'b0};
    vecs[3] = '{16'hFFFF, 12, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h7FBF, 12, 16'h7FBF, 1'b1};
    vecs[5] = '{16'h7FFD, 12, 16'h7FFD, 1'b1};
    vecs[6] = '{16'hFFFF, 12, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h0000, 25, 16'h0000, 1'b1};
    vecs[8] = '{16'hFFFF, 25, 16'hFFFF, 1'b0};

    reset_n    = 1'b0;
    keys       = 16'hFFFF;
    key_ready  = 1'b1;
    modelState = 16'hFFFF;
    repeat (3) @(posedge clk_kb);
    @(negedge clk_kb);
    checkOutput("reset_valid", key_valid, 0);
    checkOutput("reset_state", key_state, 32'hFFFF);
    checkOutput("reset_any", any_pressed, 0);
    checkOutput("reset_overflow", overflow, 0);
    reset_n = 1'b1;

    applyStimulus(16'hFFFF, 20, 1'b1);
    checkOutput("idle_valid", key_valid, 0);
    checkOutput("idle_state", key_state, 32'hFFFF);
    checkOutput("idle_overflow", overflow, 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].keys, vecs[i].hold, 1'b1);
      checkOutput($sformatf("vec%0d_state", i), key_state, {16'd0, vecs[i].expState});
      checkOutput($sformatf("vec%0d_any", i), any_pressed, {31'd0, vecs[i].expAny});
      checkOutput($sformatf("vec%0d_drained", i), sbQ.size(), 0);
    end

    // Latency: valid rises after the sixth edge of the new value and lasts one cycle.
    keys = 16'hFFFE;
    sbQ.push_back(5'h00);
    modelState = 16'hFFFE;
    firstIdx = 0;
    validCnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_kb);
      @(negedge clk_kb);
      if (key_valid) begin
        validCnt++;
        if (firstIdx == 0) firstIdx = i;
      end
    end
    checkOutput("latency", firstIdx, DEB + 2);
    checkOutput("valid_width", validCnt, 1);
    checkOutput("latency_any", any_pressed, 1);
    applyStimulus(16'hFFFF, 12, 1'b1);

    // Four simultaneous presses with the consumer stalled fill the FIFO in ascending order.
    key_ready = 1'b0;
    applyStimulus(16'h6FF6, 12, 1'b1);
    checkOutput("multi_valid", key_valid, 1);
    checkOutput("multi_head", key_code, 0);
    key_ready = 1'b1;
    repeat (8) @(posedge clk_kb);
    @(negedge clk_kb);
    checkOutput("multi_drained", sbQ.size(), 0);
    applyStimulus(16'hFFFF, 20, 1'b1);

    // Overflow: re-press of a key still pending behind a full FIFO.
    key_ready = 1'b0;
    applyStimulus(16'hFFF0, 12, 1'b1);
    checkOutput("full_valid", key_valid, 1);
    applyStimulus(16'hFFD0, 8, 1'b1);
    applyStimulus(16'hFFF0, 8, 1'b1);
    checkOutput("pre_overflow", overflow, 0);
    applyStimulus(16'hFFD0, 8, 1'b0);
    checkOutput("overflow_set", overflow, 1);
    checkOutput("overflow_head", key_code, 0);
    key_ready = 1'b1;
    repeat (12) @(posedge clk_kb);
    @(negedge clk_kb);
    checkOutput("overflow_drained", sbQ.size(), 0);
    checkOutput("overflow_sticky", overflow, 1);
    applyStimulus(16'hFFFF, 20, 1'b1);

    // Press then release key 9.
    applyStimulus(16'hFDFF, 12, 1'b1);
    applyStimulus(16'hFFFF, 12, 1'b1);
    checkOutput("key9_drained", sbQ.size(), 0);

    // Asynchronous reset in the middle of a backed-up stream.
    key_ready = 1'b0;
    applyStimulus(16'h0000, 12, 1'b1);
    checkOutput("stream_valid", key_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_valid", key_valid, 0);
    checkOutput("async_state", key_state, 32'hFFFF);
    checkOutput("async_any", any_pressed, 0);
    checkOutput("async_overflow", overflow, 0);
    sbQ.delete();
    modelState = 16'hFFFF;
    keys = 16'hFFFF;
    @(posedge clk_kb);
    @(negedge clk_kb);
    reset_n   = 1'b1;
    key_ready = 1'b1;
    applyStimulus(16'hFFFF, 12, 1'b1);
    checkOutput("post_reset_valid", key_valid, 0);

    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_event_queue.md
# keypad_event_queue

Consumes the 16-bit active-low `keys` vector produced by `keyboard_decoder` and turns it into a queue of discrete key-press codes with a valid/ready handshake. It debounces the whole vector and detects 1→0 press edges, encoding one pending key per cycle into a small FIFO. It sits between the keypad scanner and any consumer that wants events rather than levels, such as the display/calculator logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required before `keys` is accepted as stable; legal range 1..255.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2, ≥2.
- `clk_kb` in 1: the only clock; all state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `keys` in 16: raw key levels from `keyboard_decoder`; bit n = 0 means key n is pressed.
- `key_ready` in 1: consumer accepts the head entry.
- `key_valid` out 1: FIFO is non-empty.
- `key_code` out 4: index of the key at the FIFO head.
- `key_release` out 1: head entry is a release event (see Configuration).
- `key_state` out 16: debounced key levels, active-low.
- `any_pressed` out 1: `key_state != 16'hFFFF`.
- `overflow` out 1: sticky error flag; cleared only by reset.

## Operation
- Reset state:
  - `keys_q` = 16'hFFFF, `key_state` = 16'hFFFF, and debounce counter = 0.
  - Pending masks = 0 and FIFO empty.
  - Outputs: `key_valid` = 0, `key_code` = 0, `key_release` = 0, `any_pressed` = 0, `overflow` = 0.
- Debounce runs every edge, and `keys_q <= keys` always:
  - If `keys != keys_q`: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES−1: `key_state` ← `keys_q`, and the counter holds.
  - Otherwise the counter increments.
- Edge detection on any cycle where `key_state` updates to value S:
  - `press_pend |= key_state & ~S`.
  - If a press bit is already set in `press_pend` before the OR, set `overflow`.
- Encoder: each cycle with `press_pend != 0` and the FIFO not full:
  - Push the lowest set index, then clear that bit.
  - At most one push per cycle.
- When the FIFO is full, pending bits hold and are not lost.
- "Full" is evaluated on the registered count, so a same-cycle pop does not enable a push.
- FIFO behaviour:
  - Pop when `key_valid && key_ready`.
  - A simultaneous push and pop is allowed whenever the FIFO is not full.
  - `key_code`/`key_release` show the head entry and are 0 when empty.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Glitches shorter than DEBOUNCE_CYCLES never reach `key_state` and produce no events.

## Timing
- `keys` changes to new value V before edge t, then holds:
  - `key_state` = V after edge t+DEBOUNCE_CYCLES.
  - Pending bit is set at that same edge.
  - First push occurs at edge t+DEBOUNCE_CYCLES+1.
  - `key_valid` rises after that edge (latency = DEBOUNCE_CYCLES+1 cycles).
- With k simultaneous presses, events enter on k consecutive cycles in ascending index order, provided there is space.
- `key_valid` stays high until the pop edge empties the FIFO; `key_code` changes only at push-into-empty or pop edges.
- Reset asserted mid-operation clears all state immediately (asynchronously); no partial event survives.

## Configuration
- `KEYPAD_RELEASE_EVENT_EN` defined:
  - Also tracks `release_pend |= ~key_state & S` (0→1 edges); overflow rule is the same.
  - FIFO entries are 5 bits wide: `{release, code}`.
  - Encoder serves `press_pend` first, then `release_pend`, lowest index first within each.
  - `key_release` = 1 on release entries.
- Not defined:
  - Releases are ignored, entries are 4 bits wide, and `key_release` is tied to 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- Reset, `keys`=FFFF held 20 cycles → `key_valid`=0, `key_state`=FFFF, `overflow`=0.
- `keys`=FFFE from edge t, `key_ready`=1 → `key_valid` high for exactly one cycle after edge t+5 with `key_code`=0; `any_pressed`=1.
- `keys`=FFFE for 2 cycles, then FFFF → no event; `key_state` stays FFFF.
- `keys`=6FF6 (keys 0, 3, 12, 15), `key_ready`=0 → four entries; popping yields codes 0, 3, 12, 15 in order.
- FIFO full and `key_ready`=0; press key 5, release, re-press key 5 with debounce between → `overflow`=1; after draining, a single code 5 emerges.
- With `KEYPAD_RELEASE_EVENT_EN`: press then release key 9 → entries (9, `key_release`=0) then (9, `key_release`=1); reset_n pulsed mid-stream → `key_valid`=0 immediately.
